key_arbiter: RTL and testbench

Front-end controller for the 8-key / 4-LED board demo. Synchronises and debounces eight active-low push buttons and turns each debounced press into a latched pending request. A round-robin arbiter then serialises the requests into a single valid/ready event stream and drives the 4-bit LED pattern from the last accepted key. Sits between the raw key pins and any event consumer: LED logic, UART reporter or menu FSM.

---
 rtl/key_arbiter_pkg.sv | 18 +
 rtl/key_arbiter_if.sv | 14 +
 rtl/key_arbiter_debounce.sv | 59 +++++
 rtl/key_arbiter.sv | 137 +++++++++++++
 tb/tb_key_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_arbiter_pkg.sv
// Shared constants, arbiter state encoding and the code-to-LED mapping for the
// key front end.
package key_arb_pkg;

  localparam int         N_KEYS    = 8;
  localparam int         CODE_W    = 3;
  localparam logic [3:0] LED_RESET = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic logic [3:0] code_to_led(input logic [CODE_W-1:0] code);
    return 4'd14 - {1'b0, code};
  endfunction

endpackage

// File: rtl/key_arbiter_if.sv
// Key event stream from the arbiter to whichever consumer sits downstream.
interface key_arbiter_if;
  import key_arb_pkg::*;

  // valid/ready: an event moves on a clk edge where evt_valid & evt_ready are
  // both high; once evt_valid rises, evt_valid and evt_code hold until then.
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/key_arbiter_debounce.sv
// One push button: 2-flop synchroniser, tick-sampled debounce counter and a
// one-cycle press pulse when the debounced level falls.
module key_debounce #(
  parameter int DB_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_raw,
  output logic press
);

  logic       sync_q1;
  logic       sync_q2;
  logic       stable_q;
  logic       stable_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any sample agreeing with the stable level restarts the run of differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= 1'b1;
      cnt_q    <= 4'd0;
    end else if (tick) begin
      if (sync_q2 == stable_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_inc == 4'(DB_SAMPLES)) begin
        stable_q <= ~stable_q;
        cnt_q    <= 4'd0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d <= 1'b1;
    end else begin
      stable_d <= stable_q;
    end
  end

  assign press = stable_d & ~stable_q;

endmodule

// File: rtl/key_arbiter.sv
// Eight debounced active-low keys latched as pending requests and serialised
// round-robin onto a valid/ready event stream; LEDs show the last accepted key.
module key_arbiter
  import key_arb_pkg::*;
#(
  parameter int TICK_DIV   = 2000,
  parameter int DB_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_KEYS-1:0]  key,
  key_arbiter_if.master      evt,
  output logic [N_KEYS-1:0]  pending,
  output logic               dropped,
  output logic [3:0]         led,
  output arb_state_e         state_dbg
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] pending_q;
  logic [N_KEYS-1:0] clr_mask;
  logic              dropped_q;
  logic [3:0]        led_q;
  logic [CODE_W-1:0] ptr_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] grant_code;
  logic [CODE_W-1:0] idx;
  logic              grant_any;
  logic              load_grant;
  logic              accept;
  arb_state_e        state_q;
  arb_state_e        state_d;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .key_raw (key[i]),
      .press   (press_vec[i])
    );
  end

  // Walk downward so the smallest cyclic distance from ptr is the last hit kept.
  always_comb begin
    grant_any  = 1'b0;
    grant_code = ptr_q;
    idx        = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      idx = ptr_q + CODE_W'(k);
      if (pending_q[idx]) begin
        grant_any  = 1'b1;
        grant_code = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = OFFER;
      OFFER:   if (evt.evt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_grant = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE:    load_grant = grant_any;
      OFFER:   accept     = evt.evt_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      ptr_q  <= '0;
      led_q  <= LED_RESET;
    end else begin
      if (load_grant) begin
        code_q <= grant_code;
      end
      if (accept) begin
        ptr_q <= code_q + CODE_W'(1);
        led_q <= code_to_led(code_q);
      end
    end
  end

  // A press landing on the accept edge re-arms the request instead of dropping it.
  assign clr_mask = accept ? (N_KEYS'(1) << code_q) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | press_vec;
      dropped_q <= |(press_vec & pending_q & ~clr_mask);
    end
  end

  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_code  = code_q;
  assign pending       = pending_q;
  assign dropped       = dropped_q;
  assign led           = led_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter with a fast tick so debounce fits in a few cycles.
module tb_key_arbiter;
  import key_arb_pkg::*;

  localparam int TD = 4;
  localparam int DS = 2;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [N_KEYS-1:0] key   = '1;
  logic [N_KEYS-1:0] pending;
  logic              dropped;
  logic [3:0]        led;
  arb_state_e        state_dbg;

  key_arbiter_if evt_if();

  key_arbiter #(.TICK_DIV(TD), .DB_SAMPLES(DS)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .evt       (evt_if),
    .pending   (pending),
    .dropped   (dropped),
    .led       (led),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int drop_cnt = 0;
  int evt_cnt  = 0;
  logic [CODE_W-1:0] exp_q[$];

  typedef struct {
    logic [N_KEYS-1:0] mask;
    int                n_evt;
    logic [CODE_W-1:0] code0;
    logic [CODE_W-1:0] code1;
    logic [3:0]        led;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (!evt_if.evt_valid && cyc < 40) begin
      step(1);
      cyc++;
    end
    if (!evt_if.evt_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: evt_valid low after %0d cycles, required high", name, cyc);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || state_dbg != IDLE || pending != '0) && n < 100) begin
      step(1);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (dropped) drop_cnt++;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        evt_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0d, required none", evt_if.evt_code);
        end else begin
          check("event_code", 32'(evt_if.evt_code), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    int e0;
    int held;
    int n;

    vecs[0] = '{8'h08, 1, 3'd3, 3'd0, 4'b1011};
    vecs[1] = '{8'h01, 1, 3'd0, 3'd0, 4'b1110};
    vecs[2] = '{8'h80, 1, 3'd7, 3'd0, 4'b0111};
    vecs[3] = '{8'h11, 2, 3'd0, 3'd4, 4'b1010};
    vecs[4] = '{8'h44, 2, 3'd6, 3'd2, 4'b1100};

    evt_if.evt_ready = 1'b0;
    #1 reset = 1'b0;
    step(3);
    check("reset_evt_valid", 32'(evt_if.evt_valid), 32'd0);
    check("reset_evt_code", 32'(evt_if.evt_code), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_dropped", 32'(dropped), 32'd0);
    check("reset_led", 32'(led), 32'hF);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    step(2);

    // Single and paired presses with the consumer always ready.
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e0 = evt_cnt;
      exp_q.push_back(vecs[i].code0);
      if (vecs[i].n_evt == 2) exp_q.push_back(vecs[i].code1);
      key = ~vecs[i].mask;
      wait_valid("vec", lat);
      check("vec_latency_8_to_12", 32'(lat >= 8 && lat <= 12), 32'd1);
      step(20);
      key = '1;
      step(20);
      check("vec_event_count", 32'(evt_cnt - e0), 32'(vecs[i].n_evt));
      check("vec_led", 32'(led), 32'(vecs[i].led));
      check("vec_pending", 32'(pending), 32'd0);
    end
    check("table_no_drop", 32'(drop_cnt), 32'd0);

    // Bounce shorter than two ticks never settles.
    e0 = evt_cnt;
    key[0] = 1'b0; step(3);
    key[0] = 1'b1; step(5);
    key[0] = 1'b0; step(3);
    key[0] = 1'b1; step(30);
    check("bounce_pending", 32'(pending), 32'd0);
    check("bounce_events", 32'(evt_cnt - e0), 32'd0);
    check("bounce_drops", 32'(drop_cnt), 32'd0);

    // Arbitration from ptr 0 with a stalled consumer.
    evt_if.evt_ready = 1'b0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    key = ~8'h22;
    wait_valid("arb", lat);
    check("arb_first_code", 32'(evt_if.evt_code), 32'd1);
    check("arb_pending", 32'(pending), 32'h22);
    held = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (evt_if.evt_valid && evt_if.evt_code == 3'd1) held++;
    end
    check("arb_hold_cycles", 32'(held), 32'd10);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    evt_if.evt_ready = 1'b1;
    wait_drain("arb");
    check("arb_led", 32'(led), 32'b1001);
    key = '1;
    step(20);

    // Round-robin: ptr is 6, so 7 goes before 2.
    evt_if.evt_ready = 1'b0;
    key = ~8'h84;
    wait_valid("rr", lat);
    check("rr_first_code", 32'(evt_if.evt_code), 32'd7);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd2);
    evt_if.evt_ready = 1'b1;
    wait_drain("rr");
    check("rr_led", 32'(led), 32'b1100);
    key = '1;
    step(20);

    // Re-press while still pending: merged with one drop pulse.
    evt_if.evt_ready = 1'b0;
    d0 = drop_cnt;
    e0 = evt_cnt;
    key[2] = 1'b0;
    wait_valid("drop", lat);
    check("drop_code", 32'(evt_if.evt_code), 32'd2);
    step(5);
    key[2] = 1'b1; step(20);
    key[2] = 1'b0; step(20);
    check("drop_pulses", 32'(drop_cnt - d0), 32'd1);
    check("drop_pending", 32'(pending), 32'h04);
    key[2] = 1'b1; step(20);
    exp_q.push_back(3'd2);
    evt_if.evt_ready = 1'b1;
    wait_drain("drop");
    step(3);
    check("drop_event_count", 32'(evt_cnt - e0), 32'd1);

    // Re-press edge on the accept edge: set wins, second event follows.
    evt_if.evt_ready = 1'b0;
    d0 = drop_cnt;
    e0 = evt_cnt;
    key[2] = 1'b0;
    wait_valid("setwin", lat);
    step(5);
    key[2] = 1'b1; step(20);
    key[2] = 1'b0;
    n = 0;
    while (!dut.press_vec[2] && n < 40) begin
      step(1);
      n++;
    end
    check("setwin_edge_seen", 32'(dut.press_vec[2]), 32'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd2);
    evt_if.evt_ready = 1'b1;
    step(1);
    check("setwin_pending_kept", 32'(pending[2]), 32'd1);
    check("setwin_valid_low", 32'(evt_if.evt_valid), 32'd0);
    wait_drain("setwin");
    step(3);
    check("setwin_events", 32'(evt_cnt - e0), 32'd2);
    check("setwin_no_drop", 32'(drop_cnt - d0), 32'd0);
    key[2] = 1'b1;
    step(20);

    // Asynchronous reset while an event is offered.
    evt_if.evt_ready = 1'b0;
    key[4] = 1'b0;
    wait_valid("rst", lat);
    check("rst_in_offer", 32'(state_dbg), 32'(OFFER));
    #2 reset = 1'b0;
    #1;
    check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_led", 32'(led), 32'hF);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    key = '1;
    step(2);
    reset = 1'b1;
    step(20);

    // Ready with nothing offered changes nothing.
    e0 = evt_cnt;
    evt_if.evt_ready = 1'b1;
    step(5);
    check("idle_ready_led", 32'(led), 32'hF);
    check("idle_ready_events", 32'(evt_cnt - e0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
